sseg_scan_ctrl: RTL and testbench

Display controller for the board's 4-digit, common-anode seven-segment display. It captures a 16-bit value on a load strobe. In decimal mode it converts the value to BCD with a sequential shift-add-3 (double-dabble) engine. It time-multiplexes the four digits onto the shared segs/an pins. It sits in the top-level wrapper between the MCU's memory-mapped sseg output register and the board pins.

---
 rtl/sseg_scan_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_sseg_scan_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/sseg_scan_ctrl.sv
// Four-digit common-anode seven-segment controller: captures a 16-bit value, optionally
// converts it to BCD with a sequential double-dabble engine, and time-multiplexes the digits.
module sseg_scan_ctrl #(
  parameter int unsigned REFRESH_DIV = 50000,
  parameter bit          BLANK_LZ    = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] data_in,
  input  logic        load,
  input  logic        hex_mode,
  output logic        busy,
  output logic [7:0]  segs,
  output logic [3:0]  an
);

  localparam int unsigned CntW = $clog2(REFRESH_DIV);
  localparam logic [CntW-1:0] CntMax = CntW'(REFRESH_DIV - 1);

  localparam logic [7:0] SegBlank = 8'hFF;
  localparam logic [7:0] SegDash  = 8'hBF;

  typedef enum logic [1:0] {StIdle, StConv, StCommit} state_e;

  state_e          state_q, state_d;
  logic [15:0]     bin_q, bin_d;
  logic [16:0]     bcd_q, bcd_d;
  logic            ovf_q, ovf_d;
  logic [3:0]      iter_q, iter_d;
  logic [15:0]     digits_q, digits_d;
  logic            hex_q, hex_d;
  logic            dash_q, dash_d;
  logic [3:0]      blank_q, blank_d;
  logic [CntW-1:0] refresh_q, refresh_d;
  logic [1:0]      idx_q, idx_d;
  logic [7:0]      segs_q, segs_d;
  logic [3:0]      an_q, an_d;

  logic [16:0] bcd_adj;
  logic [3:0]  nib_sel;
  logic        blank_sel;

  function automatic logic [7:0] seg_enc(input logic [3:0] v);
    logic [7:0] s;
    unique case (v)
      4'h0: s = 8'hC0;
      4'h1: s = 8'hF9;
      4'h2: s = 8'hA4;
      4'h3: s = 8'hB0;
      4'h4: s = 8'h99;
      4'h5: s = 8'h92;
      4'h6: s = 8'h82;
      4'h7: s = 8'hF8;
      4'h8: s = 8'h80;
      4'h9: s = 8'h90;
      4'hA: s = 8'h88;
      4'hB: s = 8'h83;
      4'hC: s = 8'hC6;
      4'hD: s = 8'hA1;
      4'hE: s = 8'h86;
      4'hF: s = 8'h8E;
      default: s = SegBlank;
    endcase
    return s;
  endfunction

  // Add-3 correction on each BCD nibble ahead of the shift.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 4; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    bin_d    = bin_q;
    bcd_d    = bcd_q;
    ovf_d    = ovf_q;
    iter_d   = iter_q;
    digits_d = digits_q;
    hex_d    = hex_q;
    dash_d   = dash_q;
    blank_d  = blank_q;

    unique case (state_q)
      StIdle: begin
        if (load) begin
          if (hex_mode) begin
            digits_d = data_in;
            hex_d    = 1'b1;
            dash_d   = 1'b0;
            blank_d  = 4'b0000;
          end else begin
            bin_d   = data_in;
            bcd_d   = '0;
            ovf_d   = 1'b0;
            iter_d  = '0;
            state_d = StConv;
          end
        end
      end
      StConv: begin
        bcd_d  = {bcd_adj[15:0], bin_q[15]};
        bin_d  = {bin_q[14:0], 1'b0};
        // Once a ten-thousands bit appears the value can only grow, so keep it sticky.
        ovf_d  = ovf_q | bcd_adj[15];
        iter_d = iter_q + 4'd1;
        if (iter_q == 4'd15) begin
          state_d = StCommit;
        end
      end
      StCommit: begin
        digits_d = bcd_q[15:0];
        hex_d    = 1'b0;
        dash_d   = ovf_q;
        blank_d  = 4'b0000;
        if (BLANK_LZ && !ovf_q) begin
          blank_d[3] = (bcd_q[15:12] == 4'd0);
          blank_d[2] = (bcd_q[15:8] == 8'd0);
          blank_d[1] = (bcd_q[15:4] == 12'd0);
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Scan: outputs are built from next-state values so they line up with the registered state.
  always_comb begin
    refresh_d = refresh_q + 1'b1;
    idx_d     = idx_q;
    if (refresh_q == CntMax) begin
      refresh_d = '0;
      idx_d     = idx_q + 2'd1;
    end

    unique case (idx_d)
      2'd0: nib_sel = digits_d[3:0];
      2'd1: nib_sel = digits_d[7:4];
      2'd2: nib_sel = digits_d[11:8];
      2'd3: nib_sel = digits_d[15:12];
      default: nib_sel = 4'h0;
    endcase
    blank_sel = blank_d[idx_d];

    if (blank_sel) begin
      segs_d = SegBlank;
      an_d   = 4'b1111;
    end else begin
      segs_d = (dash_d && !hex_d) ? SegDash : seg_enc(nib_sel);
      an_d   = ~(4'b0001 << idx_d);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      bin_q     <= '0;
      bcd_q     <= '0;
      ovf_q     <= 1'b0;
      iter_q    <= '0;
      digits_q  <= '0;
      hex_q     <= 1'b1;
      dash_q    <= 1'b0;
      blank_q   <= 4'b0000;
      refresh_q <= '0;
      idx_q     <= 2'd0;
      segs_q    <= 8'hC0;
      an_q      <= 4'b1110;
    end else begin
      state_q   <= state_d;
      bin_q     <= bin_d;
      bcd_q     <= bcd_d;
      ovf_q     <= ovf_d;
      iter_q    <= iter_d;
      digits_q  <= digits_d;
      hex_q     <= hex_d;
      dash_q    <= dash_d;
      blank_q   <= blank_d;
      refresh_q <= refresh_d;
      idx_q     <= idx_d;
      segs_q    <= segs_d;
      an_q      <= an_d;
    end
  end

  assign busy = (state_q != StIdle);
  assign segs = segs_q;
  assign an   = an_q;

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Bench for sseg_scan_ctrl: a value-level display model feeds a scoreboard queue that a
// negedge monitor drains against the DUT's an/segs/busy every cycle.
module tb_sseg_scan_ctrl;

  localparam int RD = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic        hex_mode = 1'b0;
  logic [15:0] data_in = '0;
  logic        busy;
  logic [7:0]  segs;
  logic [3:0]  an;

  always #5 clk = ~clk;

  sseg_scan_ctrl #(
    .REFRESH_DIV(RD),
    .BLANK_LZ   (1'b1)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .data_in (data_in),
    .load    (load),
    .hex_mode(hex_mode),
    .busy    (busy),
    .segs    (segs),
    .an      (an)
  );

  typedef struct packed {
    logic [3:0] an;
    logic [7:0] segs;
    logic       busy;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;

  function automatic logic [7:0] enc(input int d);
    case (d)
      0: return 8'hC0;  1: return 8'hF9;  2: return 8'hA4;  3: return 8'hB0;
      4: return 8'h99;  5: return 8'h92;  6: return 8'h82;  7: return 8'hF8;
      8: return 8'h80;  9: return 8'h90;  10: return 8'h88; 11: return 8'h83;
      12: return 8'hC6; 13: return 8'hA1; 14: return 8'h86; default: return 8'h8E;
    endcase
  endfunction

  task automatic chk(input string nm, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, want);
    end
  endtask

  // Reference model: cycles since reset, the value on display, and a pending decimal commit.
  initial begin
    int   t, disp_val, pend, pend_val, idx, dig, p;
    bit   disp_hex, started, blk;
    logic [7:0] seg;
    logic [3:0] onehot;
    exp_t e;
    t = 0; disp_val = 0; pend = 0; pend_val = 0; disp_hex = 1'b1; started = 1'b0;
    forever begin
      @(posedge clk);
      if (rst) begin
        t = 0; disp_val = 0; disp_hex = 1'b1; pend = 0; started = 1'b1;
      end else if (started) begin
        t++;
        if (pend > 0) begin
          pend--;
          if (pend == 0) begin
            disp_val = pend_val;
            disp_hex = 1'b0;
          end
        end else if (load) begin
          if (hex_mode) begin
            disp_val = int'(data_in);
            disp_hex = 1'b1;
          end else begin
            pend     = 17;
            pend_val = int'(data_in);
          end
        end
      end
      if (started) begin
        idx = (t / RD) % 4;
        blk = 1'b0;
        if (disp_hex) begin
          seg = enc((disp_val >> (4 * idx)) & 15);
        end else if (disp_val > 9999) begin
          seg = 8'hBF;
        end else begin
          p   = (idx == 0) ? 1 : (idx == 1) ? 10 : (idx == 2) ? 100 : 1000;
          seg = enc((disp_val / p) % 10);
          blk = (idx > 0) && (disp_val < p);
        end
        onehot = 4'b0001 << idx;
        e.an   = blk ? 4'b1111 : ~onehot;
        e.segs = blk ? 8'hFF : seg;
        e.busy = (pend > 0);
        sb.push_back(e);
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("an", int'(an), int'(e.an));
        chk("segs", int'(segs), int'(e.segs));
        chk("busy", int'(busy), int'(e.busy));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input logic [15:0] v, input logic h);
    @(negedge clk);
    data_in  = v;
    hex_mode = h;
    load     = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  initial begin
    logic [15:0] dec_vals [6];
    logic [15:0] v;
    dec_vals[0] = 16'd1234;  dec_vals[1] = 16'd42;    dec_vals[2] = 16'd0;
    dec_vals[3] = 16'd10000; dec_vals[4] = 16'd65535; dec_vals[5] = 16'd9999;

    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(20);

    do_load(16'hBEEF, 1'b1);
    idle(20);
    for (int i = 0; i < 6; i++) begin
      do_load(dec_vals[i], 1'b0);
      idle(30);
    end

    // Load arriving mid-conversion is dropped.
    do_load(16'd1234, 1'b0);
    idle(3);
    do_load(16'd5678, 1'b0);
    idle(30);

    // Reset mid-conversion aborts it.
    do_load(16'd4321, 1'b0);
    idle(6);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    idle(25);

    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end else begin
        v = 16'($urandom);
        if ($urandom_range(0, 2) == 0) v = 16'($urandom_range(0, 120));
        do_load(v, 1'($urandom_range(0, 1)));
      end
      idle($urandom_range(0, 24));
    end

    idle(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
